// File: rtl/line_delay_ctrl_pkg.sv
// line_delay_ctrl_pkg: shared FSM encoding and default geometry for the line delay block
package line_delay_ctrl_pkg;
    typedef enum logic {IDLE, WRITE} state_t;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH = 11;
    localparam int DEF_LINE_LEN   = 1920;
endpackage

// File: rtl/line_delay_ctrl_linebuf.sv
// linebuf_sp_ram: single-port line RAM, read when not writing, output holds during writes
module linebuf_sp_ram
    import line_delay_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DEPTH      = DEF_LINE_LEN
) (
    input  logic                  clk,
    input  logic                  w_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (w_en) mem[addr] <= data_in;
        else data_out <= mem[addr];
endmodule

// File: rtl/line_delay_ctrl.sv
// line_delay_ctrl: pairs each pixel with the same-column pixel of the previous line
module line_delay_ctrl
    import line_delay_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int LINE_LEN   = DEF_LINE_LEN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_cur,
    output logic [DATA_WIDTH-1:0] out_prev,
    output logic                  out_first_line,
    output logic                  out_eol
);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(LINE_LEN - 1);

    state_t                state, state_nx;
    logic [ADDR_WIDTH-1:0] col;
    logic                  first_line, xfer, w_en, eol;
    logic [DATA_WIDTH-1:0] pix, ram_q;

    assign in_ready = state == IDLE && !rst;
    assign xfer     = in_valid && in_ready;
    // a write still pending when reset arrives is dropped
    assign w_en     = state == WRITE && !rst;
    assign eol      = col == LAST;

    always_comb state_nx = xfer ? WRITE : IDLE;

    linebuf_sp_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .DEPTH(LINE_LEN)
    ) u_ram (
        .clk(clk),
        .w_en(w_en),
        .addr(col),
        .data_in(pix),
        .data_out(ram_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            col            <= '0;
            first_line     <= 1'b1;
            out_valid      <= 1'b0;
            out_cur        <= '0;
            out_prev       <= '0;
            out_first_line <= 1'b0;
            out_eol        <= 1'b0;
        end else begin
            state     <= state_nx;
            out_valid <= state == WRITE;
            if (xfer) pix <= in_data;
            if (state == WRITE) begin
                out_cur        <= pix;
                out_prev       <= first_line ? '0 : ram_q;
                out_first_line <= first_line;
                out_eol        <= eol;
            end
            // frame_start wins over the column advance in either state
            if (frame_start) begin
                col        <= '0;
                first_line <= 1'b1;
            end else if (state == WRITE) begin
                col        <= eol ? '0 : col + 1'b1;
                first_line <= first_line && !eol;
            end
        end
    end
endmodule

// File: tb/tb_line_delay_ctrl.sv
// tb_line_delay_ctrl: random-stimulus bench against a pixel-level line buffer model
module tb_line_delay_ctrl;
    localparam int DW = 16;
    localparam int LL = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          frame_start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic [DW-1:0] out_cur, out_prev;
    logic          out_first_line, out_eol;

    line_delay_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(2), .LINE_LEN(LL)) dut (
        .clk(clk),
        .rst(rst),
        .frame_start(frame_start),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .out_valid(out_valid),
        .out_cur(out_cur),
        .out_prev(out_prev),
        .out_first_line(out_first_line),
        .out_eol(out_eol)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // model: one stored line, write position, one accepted-but-unwritten pixel
    int        m_line [LL];
    int        m_col = 0;
    bit        m_first = 1'b1;
    bit        m_pend = 1'b0;
    int        m_pix = 0;
    bit        e_valid = 1'b0;
    int        e_cur = 0, e_prev = 0;
    bit        e_first = 1'b0, e_eol = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one clock: drive inputs, check what the previous edge produced, advance the model
    task automatic cycle(input bit v, input logic [DW-1:0] d, input bit fs, input bit r);
        bit ev;
        rst = r;
        in_valid = v;
        in_data = d;
        frame_start = fs;
        @(negedge clk);
        check("in_ready", in_ready, !m_pend && !r);
        check("out_valid", out_valid, e_valid);
        check("out_cur", out_cur, e_cur);
        check("out_prev", out_prev, e_prev);
        check("out_first_line", out_first_line, e_first);
        check("out_eol", out_eol, e_eol);
        ev = 1'b0;
        if (r) begin
            m_pend = 1'b0;
            m_col = 0;
            m_first = 1'b1;
            e_cur = 0;
            e_prev = 0;
            e_first = 1'b0;
            e_eol = 1'b0;
        end else if (m_pend) begin
            ev = 1'b1;
            e_cur = m_pix;
            e_prev = m_first ? 0 : m_line[m_col];
            e_first = m_first;
            e_eol = m_col == LL - 1;
            m_line[m_col] = m_pix;
            m_pend = 1'b0;
            if (fs) begin
                m_col = 0;
                m_first = 1'b1;
            end else begin
                if (m_col == LL - 1) m_first = 1'b0;
                m_col = (m_col + 1) % LL;
            end
        end else begin
            if (fs) begin
                m_col = 0;
                m_first = 1'b1;
            end
            if (v) begin
                m_pix = int'(d);
                m_pend = 1'b1;
            end
        end
        e_valid = ev;
        @(posedge clk);
        #1;
    endtask

    // idle gap, accepted pixel, then the write cycle with random (ignored) in_valid
    task automatic send(input logic [DW-1:0] d, input int gap, input bit fs_acc, input bit fs_wr);
        repeat (gap) cycle(1'b0, 16'($urandom), 1'b0, 1'b0);
        cycle(1'b1, d, fs_acc, 1'b0);
        cycle(1'($urandom), 16'($urandom), fs_wr, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < LL; i++) m_line[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1);

        for (int l = 1; l <= 3; l++)
            for (int c = 0; c < LL; c++) send(16'(16 * l + c), 0, 1'b0, 1'b0);

        cycle(1'b0, '0, 1'b1, 1'b0);
        for (int k = 0; k < 3 * LL; k++) send(16'($urandom), $urandom_range(0, 5), 1'b0, 1'b0);

        cycle(1'b0, '0, 1'b1, 1'b0);
        for (int k = 0; k < LL + 2; k++) send(16'(16'h40 + k), 0, 1'b0, 1'b0);
        send(16'h46, 1, 1'b0, 1'b1);
        for (int k = 0; k < LL + 2; k++) send(16'(16'h50 + k), $urandom_range(0, 2), 1'b0, 1'b0);

        send(16'h60, 0, 1'b1, 1'b0);
        for (int k = 1; k < LL + 1; k++) send(16'(16'h60 + k), 0, 1'b0, 1'b0);

        cycle(1'b0, '0, 1'b1, 1'b0);
        for (int c = 0; c < LL; c++) send(16'(16'h10 + c), 0, 1'b0, 1'b0);
        send(16'h20, 0, 1'b0, 1'b0);
        cycle(1'b1, 16'h21, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b0);
        check("ram_addr1", dut.u_ram.mem[1], 32'(m_line[1]));
        for (int c = 0; c < 2 * LL; c++) send(16'(16'h70 + c), $urandom_range(0, 3), 1'b0, 1'b0);

        repeat (3) cycle(1'b0, '0, 1'b0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
